product_lcd_driver: RTL and testbench
=====================================

// Module: product_lcd_driver
// PURPOSE
//  Downstream display stage for the 8x8 Vedic multiplier.
//  Samples the 16-bit product once per refresh frame and converts it to 5 decimal digits.
//  Drives an HD44780-compatible 16x2 character LCD in 8-bit mode, write-only.
//  Initialises the panel after reset, then rewrites line 1 every frame.
// PARAMETERS
//  PWRUP_CYC    750_000    cycles waited after reset before the first command (15 ms at 50 MHz)
//  E_HIGH_CYC   25         cycles lcd_e is held high per write (500 ns)
//  CMD_WAIT_CYC 2_500      cycles after E falls before the next write (50 us)
//  CLR_WAIT_CYC 100_000    wait after the clear-display command 0x01 (2 ms)
//  REFRESH_CYC  1_000_000  idle cycles between frames; equals the multiplier sample period
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  product      in   16  unsigned product from the multiplier; treated as asynchronous to frames
//  lcd_data     out  8   LCD DB7..DB0
//  lcd_rs       out  1   0 = command, 1 = data
//  lcd_rw       out  1   tied 0 (write only)
//  lcd_e        out  1   LCD enable strobe
//  init_done    out  1   high once the init sequence completes; stays high until rst
//  busy         out  1   high while a frame (conversion + writes) is in progress
// BEHAVIOUR
//  Reset (synchronous, active-high, one clock):
//   - Outputs: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, init_done=0, busy=0.
//   - FSM goes to S_PWRUP and all counters clear.
//   - Reset asserted mid-write drops lcd_e on the next edge; the sequence restarts from S_PWRUP.
//  Write cycle (shared by all states; one write at a time):
//   - Cycle 0: drive lcd_data/lcd_rs with lcd_e=0 (setup).
//   - Next E_HIGH_CYC cycles: lcd_e=1.
//   - Then lcd_e=0, with data/rs held for the wait time: CLR_WAIT_CYC after cmd 0x01, else CMD_WAIT_CYC.
//   - Total cycles = 1 + E_HIGH_CYC + wait.
//  Top FSM:
//   - S_PWRUP: count PWRUP_CYC -> S_INIT.
//   - S_INIT: write commands 0x38, 0x38, 0x0C, 0x06, 0x01 in order, then set init_done=1 -> S_LATCH.
//   - S_LATCH: register product into prod_q for one cycle; set busy=1 -> S_CONV.
//   - S_CONV: double-dabble, one shift per cycle, exactly 16 cycles. Yields 5 BCD digits d4..d0 -> S_ADDR.
//   - S_ADDR: write cmd 0x80 (DDRAM line 1, col 0) -> S_DATA.
//   - S_DATA: write 5 chars, rs=1, most significant digit first.
//   - S_IDLE: busy=0; count REFRESH_CYC -> S_LATCH.
//  Digit rules:
//   - Each digit is sent as ASCII 8'h30+d.
//   - Leading zeros become ASCII space 8'h20, blanked left to right until the first nonzero digit.
//   - d0 (units) is never blanked, so value 0 displays "    0".
//   - Range 0..65535; no overflow case exists.
//  Input changes:
//   - product changes after S_LATCH are ignored until the next frame (no tearing within a frame).
//  Counters:
//   - Wait counters are wide enough for the largest parameter.
//   - Counters saturate and never wrap; each is reloaded at the start of its state.
// STRUCTURE
//  Package lcd_pkg:
//   - Command constants CMD_FUNCSET=8'h38, CMD_DISPON=8'h0C, CMD_ENTRY=8'h06, CMD_CLEAR=8'h01, CMD_LINE1=8'h80.
//   - ASCII_ZERO=8'h30, ASCII_SPACE=8'h20.
//   - Top-FSM state enum.
//  One sub-module, bin16_to_bcd5:
//   - Sequential double-dabble; start/done handshake; 16-cycle latency; outputs a 20-bit BCD value.
//   - The top FSM holds in S_CONV until done is high.
// TESTING (bench: E_HIGH_CYC=2, CMD_WAIT_CYC=4, CLR_WAIT_CYC=8, PWRUP_CYC=10, REFRESH_CYC=20)
//  1. Release rst -> lcd_e stays 0 for 10 cycles; then 5 E pulses carry 38,38,0C,06,01 with rs=0.
//     init_done rises after the 0x01 wait.
//  2. product=16'd225 -> frame writes cmd 80, then data 20,20,32,32,35 ("  225"); busy drops after the last wait.
//  3. product=0 -> data 20,20,20,20,30.  product=65535 -> data 36,35,35,33,35.
//  4. Change product 12345 -> 7 during S_DATA -> current frame completes "12345"; next frame shows "    7".
//  5. Assert rst for 1 cycle while lcd_e=1 -> lcd_e=0 and init_done=0 next cycle; full init sequence repeats.
//  6. Each E pulse: lcd_e high exactly E_HIGH_CYC cycles; lcd_data/lcd_rs stable from 1 cycle before the rise
//     through the whole wait after the fall; lcd_rw always 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and character formatting for the product LCD driver.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNCSET = 8'h38;
    localparam logic [7:0] CMD_DISPON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_LINE1   = 8'h80;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT,
        S_LATCH,
        S_CONV,
        S_ADDR,
        S_DATA,
        S_IDLE
    } state_t;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        logic [7:0] c;
        case (idx)
            3'd0, 3'd1: c = CMD_FUNCSET;
            3'd2:       c = CMD_DISPON;
            3'd3:       c = CMD_ENTRY;
            default:    c = CMD_CLEAR;
        endcase
        return c;
    endfunction

    // pos 0 is the ten-thousands digit; zeros are blanked until the first nonzero, units always shown
    function automatic logic [7:0] digit_char(input logic [19:0] bcd, input logic [2:0] pos);
        logic       lead;
        logic [3:0] d;
        logic [7:0] ch;
        lead = 1'b1;
        d    = 4'd0;
        ch   = ASCII_SPACE;
        for (int k = 0; k < 5; k++) begin
            d = bcd[(4-k)*4 +: 4];
            if (d != 4'd0 || k == 4) lead = 1'b0;
            if (k == int'(pos)) ch = lead ? ASCII_SPACE : (ASCII_ZERO + {4'd0, d});
        end
        return ch;
    endfunction

endpackage

// File: rtl/bin16_to_bcd5.sv
// Sequential double-dabble: 16-bit binary to 5 BCD digits, one shift per clock.
module bin16_to_bcd5 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        done,
    output logic [19:0] bcd
);

    logic [35:0] sh_q;
    logic [3:0]  left_q;
    logic        run_q;

    function automatic logic [35:0] dabble(input logic [35:0] x);
        logic [35:0] y;
        y = x;
        for (int k = 0; k < 5; k++) begin
            if (y[16+4*k +: 4] >= 4'd5) y[16+4*k +: 4] = y[16+4*k +: 4] + 4'd3;
        end
        return {y[34:0], 1'b0};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            left_q <= 4'd0;
            run_q  <= 1'b0;
        end else if (start) begin
            left_q <= 4'd15;
            run_q  <= 1'b1;
        end else if (left_q != 4'd0) begin
            left_q <= left_q - 4'd1;
        end
    end

    // The start edge already performs the first of the 16 shifts.
    always_ff @(posedge clk) begin
        if (start)
            sh_q <= dabble({20'd0, bin});
        else if (left_q != 4'd0)
            sh_q <= dabble(sh_q);
    end

    assign done = run_q && (left_q == 4'd0);
    assign bcd  = sh_q[35:16];

endmodule

// File: rtl/product_lcd_driver.sv
// Shows the multiplier product as a 5-digit decimal on line 1 of an HD44780 16x2 LCD (8-bit, write-only).
module product_lcd_driver
    import lcd_pkg::*;
#(
    parameter int PWRUP_CYC    = 750_000,
    parameter int E_HIGH_CYC   = 25,
    parameter int CMD_WAIT_CYC = 2_500,
    parameter int CLR_WAIT_CYC = 100_000,
    parameter int REFRESH_CYC  = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] product,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_e,
    output logic        init_done,
    output logic        busy
);

    localparam int MAX_A   = (PWRUP_CYC > REFRESH_CYC) ? PWRUP_CYC : REFRESH_CYC;
    localparam int MAX_B   = 1 + E_HIGH_CYC + ((CLR_WAIT_CYC > CMD_WAIT_CYC) ? CLR_WAIT_CYC : CMD_WAIT_CYC);
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] PWRUP_LAST   = CW'(PWRUP_CYC - 1);
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_CYC - 1);
    localparam logic [CW-1:0] E_LAST       = CW'(E_HIGH_CYC);
    localparam logic [CW-1:0] CMD_LAST     = CW'(E_HIGH_CYC + CMD_WAIT_CYC);
    localparam logic [CW-1:0] CLR_LAST     = CW'(E_HIGH_CYC + CLR_WAIT_CYC);
    localparam logic [CW-1:0] CNT_SAT      = {CW{1'b1}};

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, ld_data;
    logic          rs_q, ld_rs;
    logic          init_done_q;
    logic [15:0]   prod_q;
    logic          cnt_clr, load, init_set, latch, conv_start, wr_last, in_write;
    logic          bcd_done;
    logic [19:0]   bcd;

    bin16_to_bcd5 u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (prod_q),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    // Within a write, cnt_q: 0 = setup, 1..E_HIGH_CYC = strobe, then the hold/wait cycles.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_clr    = 1'b0;
        load       = 1'b0;
        ld_data    = data_q;
        ld_rs      = rs_q;
        init_set   = 1'b0;
        latch      = 1'b0;
        conv_start = 1'b0;
        wr_last    = (cnt_q == ((!rs_q && data_q == CMD_CLEAR) ? CLR_LAST : CMD_LAST));
        case (state_q)
            S_PWRUP: begin
                if (cnt_q == PWRUP_LAST) begin
                    state_d = S_INIT;
                    cnt_clr = 1'b1;
                    idx_d   = 3'd0;
                    load    = 1'b1;
                    ld_data = init_cmd(3'd0);
                    ld_rs   = 1'b0;
                end
            end
            S_INIT: begin
                if (wr_last) begin
                    cnt_clr = 1'b1;
                    if (idx_q == 3'd4) begin
                        state_d  = S_LATCH;
                        init_set = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        load    = 1'b1;
                        ld_data = init_cmd(idx_q + 3'd1);
                        ld_rs   = 1'b0;
                    end
                end
            end
            S_LATCH: begin
                latch   = 1'b1;
                state_d = S_CONV;
                cnt_clr = 1'b1;
            end
            S_CONV: begin
                // done may still be high from the previous frame during the start cycle
                conv_start = (cnt_q == '0);
                if (cnt_q != '0 && bcd_done) begin
                    state_d = S_ADDR;
                    cnt_clr = 1'b1;
                    load    = 1'b1;
                    ld_data = CMD_LINE1;
                    ld_rs   = 1'b0;
                end
            end
            S_ADDR: begin
                if (wr_last) begin
                    state_d = S_DATA;
                    cnt_clr = 1'b1;
                    idx_d   = 3'd0;
                    load    = 1'b1;
                    ld_data = digit_char(bcd, 3'd0);
                    ld_rs   = 1'b1;
                end
            end
            S_DATA: begin
                if (wr_last) begin
                    cnt_clr = 1'b1;
                    if (idx_q == 3'd4) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        load    = 1'b1;
                        ld_data = digit_char(bcd, idx_q + 3'd1);
                        ld_rs   = 1'b1;
                    end
                end
            end
            S_IDLE: begin
                if (cnt_q == REFRESH_LAST) begin
                    state_d = S_LATCH;
                    cnt_clr = 1'b1;
                end
            end
            default: state_d = S_PWRUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_PWRUP;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            data_q      <= 8'h00;
            rs_q        <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (cnt_clr)
                cnt_q <= '0;
            else if (cnt_q != CNT_SAT)
                cnt_q <= cnt_q + 1'b1;
            if (load) begin
                data_q <= ld_data;
                rs_q   <= ld_rs;
            end
            if (init_set) init_done_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (latch) prod_q <= product;
    end

    assign in_write  = (state_q == S_INIT) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign lcd_e     = in_write && (cnt_q != '0) && (cnt_q <= E_LAST);
    assign lcd_data  = data_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign init_done = init_done_q;
    assign busy      = (state_q == S_LATCH) || (state_q == S_CONV) ||
                       (state_q == S_ADDR)  || (state_q == S_DATA);

endmodule

// File: tb/tb_product_lcd_driver.sv
// Self-checking bench: LCD bus monitor plus decimal-formatting reference model.
module tb_product_lcd_driver;

    localparam int PW  = 10;
    localparam int EH  = 2;
    localparam int CMW = 4;
    localparam int CLW = 8;
    localparam int RF  = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] product = 16'd0;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_e, init_done, busy;

    product_lcd_driver #(
        .PWRUP_CYC    (PW),
        .E_HIGH_CYC   (EH),
        .CMD_WAIT_CYC (CMW),
        .CLR_WAIT_CYC (CLW),
        .REFRESH_CYC  (RF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .product   (product),
        .lcd_data  (lcd_data),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .init_done (init_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] data;
        logic       rs;
        int         hi;
        bit         stable;
        int         rise_cyc;
        int         fall_cyc;
    } pulse_t;

    pulse_t     pq[$];
    pulse_t     allq[$];
    pulse_t     cur;
    int         m_st = 0, m_w = 0, m_wexp = 0;
    logic       prev_e = 1'b0, prev_rs = 1'b0, prev_init = 1'b0, prev_busy = 1'b0;
    logic [7:0] prev_data = 8'h00;
    bit         rw_bad = 1'b0;
    int         init_rise_cyc = -1;
    int         busy_fall_cyc = -1;
    int         rel_cyc = 0;

    // Bus monitor: one record per completed write (strobe plus its full hold window).
    always @(negedge clk) begin
        if (lcd_rw !== 1'b0) rw_bad = 1'b1;
        if (rst) begin
            m_st = 0;
        end else begin
            case (m_st)
                0: if (lcd_e === 1'b1 && prev_e !== 1'b1) begin
                    cur.data     = lcd_data;
                    cur.rs       = lcd_rs;
                    cur.hi       = 1;
                    cur.stable   = (lcd_data === prev_data) && (lcd_rs === prev_rs);
                    cur.rise_cyc = cyc;
                    cur.fall_cyc = -1;
                    m_st = 1;
                end
                1: begin
                    if (lcd_data !== cur.data || lcd_rs !== cur.rs) cur.stable = 1'b0;
                    if (lcd_e === 1'b1) begin
                        cur.hi = cur.hi + 1;
                    end else begin
                        cur.fall_cyc = cyc;
                        m_w    = 1;
                        m_wexp = (cur.rs === 1'b0 && cur.data === 8'h01) ? CLW : CMW;
                        if (m_w >= m_wexp) begin
                            pq.push_back(cur); allq.push_back(cur); m_st = 0;
                        end else begin
                            m_st = 2;
                        end
                    end
                end
                default: begin
                    if (lcd_e !== 1'b0 || lcd_data !== cur.data || lcd_rs !== cur.rs) cur.stable = 1'b0;
                    m_w = m_w + 1;
                    if (m_w >= m_wexp) begin
                        pq.push_back(cur); allq.push_back(cur); m_st = 0;
                    end
                end
            endcase
        end
        if (init_done === 1'b1 && prev_init !== 1'b1) init_rise_cyc = cyc;
        if (busy === 1'b0 && prev_busy === 1'b1) busy_fall_cyc = cyc;
        prev_e    = lcd_e;
        prev_data = lcd_data;
        prev_rs   = lcd_rs;
        prev_init = init_done;
        prev_busy = busy;
    end

    // Reference: character at position pos (0 = ten-thousands) of the right-aligned decimal value.
    function automatic logic [7:0] exp_char(input int v, input int pos);
        int p10;
        p10 = 10 ** (4 - pos);
        if (pos < 4 && v < p10) return 8'h20;
        return 8'h30 + 8'((v / p10) % 10);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic get_pulse(output pulse_t p, output bit ok);
        ok = 1'b0;
        p  = '{default: 0};
        for (int i = 0; i < 500; i++) begin
            if (pq.size() > 0) begin
                p  = pq.pop_front();
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        product = 16'd225;
        repeat (3) tick();
        vectors++; if (lcd_e !== 1'b0) begin miscompares++; $display("FAIL reset_lcd_e: got %b want 0", lcd_e); end
        vectors++; if (lcd_rs !== 1'b0) begin miscompares++; $display("FAIL reset_lcd_rs: got %b want 0", lcd_rs); end
        vectors++; if (lcd_rw !== 1'b0) begin miscompares++; $display("FAIL reset_lcd_rw: got %b want 0", lcd_rw); end
        vectors++; if (lcd_data !== 8'h00) begin miscompares++; $display("FAIL reset_lcd_data: got %h want 00", lcd_data); end
        vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        rel_cyc = cyc;
        pq.delete();
    endtask

    task automatic test_init(input int rel);
        logic [7:0] exp_cmd [5];
        pulse_t     p;
        bit         ok;
        int         clr_fall;
        exp_cmd  = '{8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
        clr_fall = -1;
        init_rise_cyc = -1;
        for (int i = 0; i < 5; i++) begin
            get_pulse(p, ok);
            vectors++;
            if (!ok) begin
                miscompares++; $display("FAIL init_cmd%0d: got no strobe want %h", i, exp_cmd[i]);
                return;
            end
            if ({p.rs, p.data} !== {1'b0, exp_cmd[i]}) begin
                miscompares++; $display("FAIL init_cmd%0d: got rs=%b data=%h want rs=0 data=%h", i, p.rs, p.data, exp_cmd[i]);
            end
            if (i == 0) begin
                vectors++;
                if (p.rise_cyc != rel + PW + 1) begin
                    miscompares++; $display("FAIL init_first_rise: got cycle %0d want %0d", p.rise_cyc - rel, PW + 1);
                end
            end
            if (i == 4) clr_fall = p.fall_cyc;
        end
        for (int i = 0; i < 50 && init_done !== 1'b1; i++) tick();
        @(negedge clk); #1;
        vectors++;
        if (init_rise_cyc != clr_fall + CLW) begin
            miscompares++; $display("FAIL init_done_rise: got %0d want %0d cycles after clear fall", init_rise_cyc - clr_fall, CLW);
        end
    endtask

    task automatic test_frame(input int val, input int mid, input int nxt);
        pulse_t     p;
        bit         ok;
        logic [8:0] expv;
        int         last_fall;
        last_fall = -1;
        busy_fall_cyc = -1;
        for (int i = 0; i < 6; i++) begin
            get_pulse(p, ok);
            expv = (i == 0) ? {1'b0, 8'h80} : {1'b1, exp_char(val, i - 1)};
            vectors++;
            if (!ok) begin
                miscompares++; $display("FAIL frame_%0d_w%0d: got no strobe want %h", val, i, expv);
                return;
            end
            if ({p.rs, p.data} !== expv) begin
                miscompares++; $display("FAIL frame_%0d_w%0d: got %h want %h", val, i, {p.rs, p.data}, expv);
            end
            if (i == 0) begin
                vectors++;
                if (busy !== 1'b1) begin miscompares++; $display("FAIL frame_%0d_busy: got %b want 1", val, busy); end
            end
            if (i == 2 && mid >= 0) product = mid[15:0];
            if (i == 5) last_fall = p.fall_cyc;
        end
        for (int i = 0; i < 50 && busy !== 1'b0; i++) tick();
        @(negedge clk); #1;
        vectors++;
        if (busy_fall_cyc != last_fall + CMW) begin
            miscompares++; $display("FAIL frame_%0d_busy_drop: got %0d want %0d cycles after last fall", val, busy_fall_cyc - last_fall, CMW);
        end
        product = nxt[15:0];
    endtask

    task automatic test_no_tearing();
        test_frame(12345, 7, 7);
        test_frame(7, -1, 7);
    endtask

    task automatic test_reset_mid_write();
        int n;
        n = 0;
        while (lcd_e !== 1'b1 && n < 500) begin tick(); n++; end
        vectors++;
        if (lcd_e !== 1'b1) begin
            miscompares++; $display("FAIL midreset_find_strobe: got lcd_e=%b want 1", lcd_e);
            return;
        end
        rst = 1'b1;
        tick();
        vectors++; if (lcd_e !== 1'b0) begin miscompares++; $display("FAIL midreset_lcd_e: got %b want 0", lcd_e); end
        vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL midreset_init_done: got %b want 0", init_done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", busy); end
        rst = 1'b0;
        rel_cyc = cyc;
        pq.delete();
        test_init(rel_cyc);
        test_frame(7, -1, 7);
    endtask

    task automatic test_pulse_timing();
        foreach (allq[i]) begin
            vectors++;
            if (allq[i].hi != EH) begin
                miscompares++; $display("FAIL strobe_width_%0d: got %0d want %0d", i, allq[i].hi, EH);
            end
            vectors++;
            if (!allq[i].stable) begin
                miscompares++; $display("FAIL bus_stable_%0d: got unstable data=%h want stable", i, allq[i].data);
            end
        end
        vectors++;
        if (rw_bad) begin miscompares++; $display("FAIL lcd_rw_low: got 1 want 0"); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int vals [9];
        vals[0] = 225;
        vals[1] = 0;
        vals[2] = 65535;
        vals[3] = 10;
        vals[4] = 9999;
        vals[5] = int'($urandom_range(0, 65535));
        vals[6] = int'($urandom_range(0, 65535));
        vals[7] = int'($urandom_range(0, 999));
        vals[8] = 12345;
        test_reset();
        test_init(rel_cyc);
        for (int i = 0; i < 8; i++) test_frame(vals[i], -1, vals[i + 1]);
        test_no_tearing();
        test_reset_mid_write();
        test_pulse_timing();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
